// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and defaults for the continuous monitoring system.
// Holds ctrl addresses, counter modes and snapshot FSM states.
package continuous_monitoring_system_pkg;

   localparam int NO_OF_PERFORMANCE_EVENTS = 39;
   localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 7;

   typedef enum logic [7:0] {
      PERF_MODE             = 8'h20,
      PERF_CLEAR            = 8'h21,
      PERF_ENABLE_MASK_BASE = 8'h22
   } perf_ctrl_addr_t;

   typedef enum logic {
      MOD = 1'b0,
      SAT = 1'b1
   } perf_count_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } perf_snap_state_t;

endpackage

// File: rtl/perf_event_mod_counters_channel.sv
// One event channel: modulo/saturating counter with sticky overflow.
// Clear beats restart; restart seeds the new window with a coincident event.
module perf_event_counter_channel
   import continuous_monitoring_system_pkg::*;
#(
   parameter int COUNTER_WIDTH = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ev,
   input  logic                     en,
   input  perf_count_mode_t         mode,
   input  logic                     restart,
   input  logic                     clear,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     overflow
);

   logic hit;
   logic at_max;

   always_comb begin
      hit    = ev && en;
      at_max = (count == '1);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (restart) begin
         count    <= hit ? COUNTER_WIDTH'(1) : '0;
         overflow <= 1'b0;
      end else if (hit) begin
         if (at_max) begin
            overflow <= 1'b1;
            if (mode == MOD) count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/perf_event_mod_counters.sv
// Bank of per-event counters with snapshot handoff over valid/ready.
// Requests while a snapshot is still held are dropped and counted.
module perf_event_mod_counters
   import continuous_monitoring_system_pkg::*;
#(
   parameter int NUM_EVENTS         = NO_OF_PERFORMANCE_EVENTS,
   parameter int COUNTER_WIDTH      = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
   parameter int CTRL_ADDR_WIDTH    = 8,
   parameter int CTRL_DATA_WIDTH    = 64,
   parameter int DROP_COUNTER_WIDTH = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_EVENTS-1:0]               performance_events,
   input  logic                                snapshot_req,
   input  logic                                ctrl_wr_en,
   input  logic [CTRL_ADDR_WIDTH-1:0]          ctrl_addr,
   input  logic [CTRL_DATA_WIDTH-1:0]          ctrl_wdata,
   output logic                                snap_valid,
   input  logic                                snap_ready,
   output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] snap_counts,
   output logic [NUM_EVENTS-1:0]               snap_overflow,
   output logic [DROP_COUNTER_WIDTH-1:0]       dropped_snapshots
);

   localparam int W = COUNTER_WIDTH;

   perf_snap_state_t state;
   perf_count_mode_t mode;

   logic [NUM_EVENTS-1:0]   mask;
   logic [NUM_EVENTS-1:0]   ovf;
   logic [NUM_EVENTS*W-1:0] counts;
   logic                    clear;
   logic                    capture;
   logic                    drop;
   logic                    unused_wdata;

   assign unused_wdata = ^ctrl_wdata;

   always_comb begin
      clear   = ctrl_wr_en &&
                (ctrl_addr == CTRL_ADDR_WIDTH'(PERF_CLEAR));
      capture = snapshot_req && ((state == IDLE) || snap_ready);
      drop    = snapshot_req && (state == HOLD) && !snap_ready;
   end

   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ch
      perf_event_counter_channel #(
         .COUNTER_WIDTH(W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .ev      (performance_events[i]),
         .en      (mask[i]),
         .mode    (mode),
         .restart (capture),
         .clear   (clear),
         .count   (counts[i*W +: W]),
         .overflow(ovf[i])
      );
   end

   // Ctrl registers: mode select and the banked enable mask words.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= MOD;
         mask <= '1;
      end else if (ctrl_wr_en) begin
         if (ctrl_addr == CTRL_ADDR_WIDTH'(PERF_MODE))
            mode <= perf_count_mode_t'(ctrl_wdata[0]);
         for (int i = 0; i < NUM_EVENTS; i++) begin
            if (int'(ctrl_addr) ==
                int'(PERF_ENABLE_MASK_BASE) + i / CTRL_DATA_WIDTH)
               mask[i] <= ctrl_wdata[i % CTRL_DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         dropped_snapshots <= '0;
      end else if (drop && (dropped_snapshots != '1)) begin
         dropped_snapshots <= dropped_snapshots + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         snap_valid    <= 1'b0;
         snap_counts   <= '0;
         snap_overflow <= '0;
      end else begin
         if (capture) begin
            snap_counts   <= counts;
            snap_overflow <= ovf;
         end
         unique case (state)
            IDLE: begin
               if (capture) begin
                  state      <= HOLD;
                  snap_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (snap_ready && !snapshot_req) begin
                  state      <= IDLE;
                  snap_valid <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               snap_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_event_mod_counters.sv
// Directed bench for perf_event_mod_counters at default parameters.
module tb_perf_event_mod_counters;

   localparam int N  = 39;
   localparam int W  = 7;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    performance_events;
   logic            snapshot_req;
   logic            ctrl_wr_en;
   logic [7:0]      ctrl_addr;
   logic [63:0]     ctrl_wdata;
   logic            snap_valid;
   logic            snap_ready;
   logic [N*W-1:0]  snap_counts;
   logic [N-1:0]    snap_overflow;
   logic [DW-1:0]   dropped_snapshots;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   perf_event_mod_counters dut (
      .clk               (clk),
      .rst               (rst),
      .performance_events(performance_events),
      .snapshot_req      (snapshot_req),
      .ctrl_wr_en        (ctrl_wr_en),
      .ctrl_addr         (ctrl_addr),
      .ctrl_wdata        (ctrl_wdata),
      .snap_valid        (snap_valid),
      .snap_ready        (snap_ready),
      .snap_counts       (snap_counts),
      .snap_overflow     (snap_overflow),
      .dropped_snapshots (dropped_snapshots)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic events(input int ch, input int n);
      performance_events[ch] = 1'b1;
      repeat (n) cyc();
      performance_events[ch] = 1'b0;
   endtask

   task automatic do_snap();
      snapshot_req = 1'b1;
      cyc();
      snapshot_req = 1'b0;
   endtask

   task automatic release_snap();
      snap_ready = 1'b1;
      cyc();
      snap_ready = 1'b0;
   endtask

   task automatic ctrl_write(input logic [7:0] a, input logic [63:0] d);
      ctrl_wr_en = 1'b1;
      ctrl_addr  = a;
      ctrl_wdata = d;
      cyc();
      ctrl_wr_en = 1'b0;
   endtask

   function automatic logic [W-1:0] cnt(input int ch);
      return snap_counts[ch*W +: W];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      total++;
      if (snap_valid !== 1'b0)
         $display("FAIL reset_valid got %0b want 0", snap_valid);
      else pass_cnt++;
      total++;
      if (snap_counts !== '0)
         $display("FAIL reset_counts got %0h want 0", snap_counts);
      else pass_cnt++;
      total++;
      if (snap_overflow !== '0)
         $display("FAIL reset_ovf got %0h want 0", snap_overflow);
      else pass_cnt++;
      total++;
      if (dropped_snapshots !== '0)
         $display("FAIL reset_drop got %0d want 0", dropped_snapshots);
      else pass_cnt++;
   endtask

   task automatic test_mod_wrap();
      events(0, 130);
      snap_ready = 1'b1;
      do_snap();
      total++;
      if (snap_valid !== 1'b1)
         $display("FAIL mod_valid got %0b want 1", snap_valid);
      else pass_cnt++;
      total++;
      if (cnt(0) !== 7'd2)
         $display("FAIL mod_count got %0d want 2", cnt(0));
      else pass_cnt++;
      total++;
      if (snap_overflow !== 39'h1)
         $display("FAIL mod_ovf got %0h want 1", snap_overflow);
      else pass_cnt++;
      total++;
      if ((snap_counts >> W) !== '0)
         $display("FAIL mod_others got %0h want 0", snap_counts >> W);
      else pass_cnt++;
      cyc();
      snap_ready = 1'b0;
      total++;
      if (snap_valid !== 1'b0)
         $display("FAIL mod_idle got %0b want 0", snap_valid);
      else pass_cnt++;
   endtask

   task automatic test_sat();
      ctrl_write(8'h20, 64'h1);
      events(3, 200);
      do_snap();
      total++;
      if (cnt(3) !== 7'd127)
         $display("FAIL sat_count got %0d want 127", cnt(3));
      else pass_cnt++;
      total++;
      if (snap_overflow[3] !== 1'b1)
         $display("FAIL sat_ovf got %0b want 1", snap_overflow[3]);
      else pass_cnt++;
      release_snap();
      events(3, 5);
      do_snap();
      total++;
      if (cnt(3) !== 7'd5)
         $display("FAIL sat_count2 got %0d want 5", cnt(3));
      else pass_cnt++;
      total++;
      if (snap_overflow[3] !== 1'b0)
         $display("FAIL sat_ovf2 got %0b want 0", snap_overflow[3]);
      else pass_cnt++;
      release_snap();
      ctrl_write(8'h20, 64'h0);
   endtask

   task automatic test_capture_event();
      events(1, 10);
      performance_events[1] = 1'b1;
      do_snap();
      performance_events[1] = 1'b0;
      total++;
      if (cnt(1) !== 7'd10)
         $display("FAIL cap_count got %0d want 10", cnt(1));
      else pass_cnt++;
      release_snap();
      events(1, 4);
      do_snap();
      total++;
      if (cnt(1) !== 7'd5)
         $display("FAIL cap_next got %0d want 5", cnt(1));
      else pass_cnt++;
      release_snap();
   endtask

   task automatic test_back_to_back();
      events(2, 5);
      do_snap();
      performance_events[2] = 1'b1;
      snapshot_req = 1'b1;
      repeat (3) cyc();
      performance_events[2] = 1'b0;
      snapshot_req = 1'b0;
      total++;
      if (dropped_snapshots !== 16'd3)
         $display("FAIL bp_drop got %0d want 3", dropped_snapshots);
      else pass_cnt++;
      total++;
      if (cnt(2) !== 7'd5)
         $display("FAIL bp_stable got %0d want 5", cnt(2));
      else pass_cnt++;
      snap_ready   = 1'b1;
      snapshot_req = 1'b1;
      cyc();
      snap_ready   = 1'b0;
      snapshot_req = 1'b0;
      total++;
      if (cnt(2) !== 7'd3)
         $display("FAIL bp_new got %0d want 3", cnt(2));
      else pass_cnt++;
      cyc();
      total++;
      if (snap_valid !== 1'b1)
         $display("FAIL bp_valid got %0b want 1", snap_valid);
      else pass_cnt++;
      release_snap();
   endtask

   task automatic test_enable_mask();
      ctrl_write(8'h22, 64'hFFFF_FFFF_FFFF_FFFE);
      performance_events[1:0] = 2'b11;
      repeat (6) cyc();
      performance_events[1:0] = 2'b00;
      ctrl_write(8'h7F, 64'h0);
      performance_events[1:0] = 2'b11;
      repeat (2) cyc();
      performance_events[1:0] = 2'b00;
      do_snap();
      total++;
      if (cnt(0) !== 7'd0)
         $display("FAIL mask_ch0 got %0d want 0", cnt(0));
      else pass_cnt++;
      total++;
      if (cnt(1) !== 7'd8)
         $display("FAIL mask_ch1 got %0d want 8", cnt(1));
      else pass_cnt++;
      release_snap();
      ctrl_write(8'h22, '1);
   endtask

   task automatic test_clear();
      events(4, 4);
      ctrl_wr_en   = 1'b1;
      ctrl_addr    = 8'h21;
      ctrl_wdata   = '0;
      performance_events[4] = 1'b1;
      do_snap();
      ctrl_wr_en   = 1'b0;
      performance_events[4] = 1'b0;
      total++;
      if (cnt(4) !== 7'd4)
         $display("FAIL clr_snap got %0d want 4", cnt(4));
      else pass_cnt++;
      total++;
      if (dropped_snapshots !== 16'd0)
         $display("FAIL clr_drop got %0d want 0", dropped_snapshots);
      else pass_cnt++;
      release_snap();
      do_snap();
      total++;
      if (cnt(4) !== 7'd0)
         $display("FAIL clr_live got %0d want 0", cnt(4));
      else pass_cnt++;
      release_snap();
   endtask

   task automatic test_reset_hold();
      events(5, 2);
      do_snap();
      do_snap();
      total++;
      if (dropped_snapshots !== 16'd1)
         $display("FAIL rh_drop got %0d want 1", dropped_snapshots);
      else pass_cnt++;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      total++;
      if (snap_valid !== 1'b0)
         $display("FAIL rh_valid got %0b want 0", snap_valid);
      else pass_cnt++;
      total++;
      if (snap_counts !== '0 || snap_overflow !== '0)
         $display("FAIL rh_snap got %0h want 0", snap_counts);
      else pass_cnt++;
      total++;
      if (dropped_snapshots !== 16'd0)
         $display("FAIL rh_dropz got %0d want 0", dropped_snapshots);
      else pass_cnt++;
      events(5, 3);
      do_snap();
      total++;
      if (cnt(5) !== 7'd3)
         $display("FAIL rh_restart got %0d want 3", cnt(5));
      else pass_cnt++;
      release_snap();
   endtask

   initial begin
      rst                = 1'b1;
      performance_events = '0;
      snapshot_req       = 1'b0;
      ctrl_wr_en         = 1'b0;
      ctrl_addr          = '0;
      ctrl_wdata         = '0;
      snap_ready         = 1'b0;
      test_reset();
      test_mod_wrap();
      test_sat();
      test_capture_event();
      test_back_to_back();
      test_enable_mask();
      test_clear();
      test_reset_hold();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
